// File: rtl/conv_line_buffer.sv
// conv_line_buffer: four rotating line memories feeding a 3x3 convolution.
// Each accepted pixel is written into the current write bank. The same column is read from
// the other three banks, giving three vertically aligned pixels (lines v-3, v-2, v-1) two
// cycles later. Output valid is withheld until three full lines have been captured after reset.
module conv_line_buffer #(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      pixel_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             data_valid_in,
    output logic [2:0][15:0] data_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out,
    output logic             data_valid_out
);

    localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [10:0] HRES_L    = 11'(HRES);
    localparam logic [10:0] HLAST     = 11'(HRES - 1);
    localparam logic [9:0]  VRES_M2   = 10'(VRES - 2);
    localparam logic [1:0]  FILL_FULL = 2'd3;

    // Line storage; contents are never reset.
    logic [15:0] mem_q [4][HRES];
    logic [15:0] rd_q  [4];

    // Write bank pointer and count of completed lines since reset (saturates at 3).
    logic [1:0] wr_sel_q, wr_sel_d;
    logic [1:0] fill_cnt_q, fill_cnt_d;

    // Stage 1: control travelling alongside the memory read.
    logic        s1_valid_q, s1_valid_d;
    logic [10:0] s1_hcount_q, s1_hcount_d;
    logic [9:0]  s1_vcount_q, s1_vcount_d;
    logic [1:0]  s1_sel_q, s1_sel_d;

    // Stage 2: output registers.
    logic [2:0][15:0] data_out_q, data_out_d;
    logic [10:0]      hcount_out_q, hcount_out_d;
    logic [9:0]       vcount_out_q, vcount_out_d;
    logic             data_valid_out_q, data_valid_out_d;

    logic          acc;
    logic          line_end;
    logic [AW-1:0] addr;
    logic [9:0]    vcentre;
    logic [1:0]    sel_top, sel_mid, sel_bot;

    // Blanking columns (hcount >= HRES) are ignored entirely.
    assign acc      = data_valid_in && (hcount_in < HRES_L);
    assign line_end = acc && (hcount_in == HLAST);
    assign addr     = hcount_in[AW-1:0];

    // Centre line is two lines above the incoming one, wrapping into the previous frame.
    assign vcentre = (vcount_in < 10'd2) ? (vcount_in + VRES_M2) : (vcount_in - 10'd2);

    // Read banks are the three that are not being written, oldest line on top.
    assign sel_top = s1_sel_q + 2'd1;
    assign sel_mid = s1_sel_q + 2'd2;
    assign sel_bot = s1_sel_q + 2'd3;

    // Bank rotation and priming counter advance on the last pixel of each line.
    always_comb begin
        wr_sel_d   = wr_sel_q;
        fill_cnt_d = fill_cnt_q;
        if (line_end) begin
            wr_sel_d = wr_sel_q + 2'd1;
            if (fill_cnt_q != FILL_FULL) begin
                fill_cnt_d = fill_cnt_q + 2'd1;
            end
        end
    end

    // Stage 1 next state: capture the bank mapping before any same-cycle rotation.
    always_comb begin
        s1_valid_d  = acc && (fill_cnt_q == FILL_FULL);
        s1_hcount_d = s1_hcount_q;
        s1_vcount_d = s1_vcount_q;
        s1_sel_d    = s1_sel_q;
        if (acc) begin
            s1_hcount_d = hcount_in;
            s1_vcount_d = vcentre;
            s1_sel_d    = wr_sel_q;
        end
    end

    // Stage 2 next state: outputs update only on valid data and hold otherwise.
    always_comb begin
        data_out_d       = data_out_q;
        hcount_out_d     = hcount_out_q;
        vcount_out_d     = vcount_out_q;
        data_valid_out_d = s1_valid_q;
        if (s1_valid_q) begin
            data_out_d[0] = rd_q[sel_top];
            data_out_d[1] = rd_q[sel_mid];
            data_out_d[2] = rd_q[sel_bot];
            hcount_out_d  = s1_hcount_q;
            vcount_out_d  = s1_vcount_q;
        end
    end

    // Memory write and registered read of all banks at the incoming column.
    always_ff @(posedge clk_in) begin
        if (acc) begin
            mem_q[wr_sel_q][addr] <= pixel_in;
            for (int b = 0; b < 4; b++) begin
                rd_q[b] <= mem_q[b][addr];
            end
        end
    end

    // Control state and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_sel_q         <= 2'd0;
            fill_cnt_q       <= 2'd0;
            s1_valid_q       <= 1'b0;
            s1_hcount_q      <= 11'd0;
            s1_vcount_q      <= 10'd0;
            s1_sel_q         <= 2'd0;
            data_out_q       <= '0;
            hcount_out_q     <= 11'd0;
            vcount_out_q     <= 10'd0;
            data_valid_out_q <= 1'b0;
        end else begin
            wr_sel_q         <= wr_sel_d;
            fill_cnt_q       <= fill_cnt_d;
            s1_valid_q       <= s1_valid_d;
            s1_hcount_q      <= s1_hcount_d;
            s1_vcount_q      <= s1_vcount_d;
            s1_sel_q         <= s1_sel_d;
            data_out_q       <= data_out_d;
            hcount_out_q     <= hcount_out_d;
            vcount_out_q     <= vcount_out_d;
            data_valid_out_q <= data_valid_out_d;
        end
    end

    assign data_out       = data_out_q;
    assign hcount_out     = hcount_out_q;
    assign vcount_out     = vcount_out_q;
    assign data_valid_out = data_valid_out_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer with HRES=4, VRES=8.
// Stimulus pushes one expected record per driven cycle; the monitor pops it when due.
module tb_conv_line_buffer;

    localparam int HRES = 4;
    localparam int VRES = 8;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic [15:0]      pixel_in = '0;
    logic [10:0]      hcount_in = '0;
    logic [9:0]       vcount_in = '0;
    logic             data_valid_in = 1'b0;
    logic [2:0][15:0] data_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;

    conv_line_buffer #(.HRES(HRES), .VRES(VRES)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pixel_in      (pixel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .data_valid_in (data_valid_in),
        .data_out      (data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .data_valid_out(data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        valid;
        logic [47:0] data;
        logic [10:0] h;
        logic [9:0]  v;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Pixel of stream line seq at column h: column in the top nibble, line tag below.
    function automatic logic [15:0] pix(input int seq, input int h);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(seq + 1) & 16'h0FFF;
        hi = 16'(h) << 12;
        return hi | lo;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle and record the expected output two edges later.
    task automatic drive(input logic vld, input int h, input int v, input logic [15:0] px,
                         input logic ev, input int seq, input int ev_v);
        exp_t e;
        @(posedge clk_in);
        #1;
        data_valid_in = vld;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pixel_in      = px;
        e.due   = cyc + 2;
        e.valid = ev;
        e.data  = {pix(seq - 1, h), pix(seq - 2, h), pix(seq - 3, h)};
        e.h     = 11'(h);
        e.v     = 10'(ev_v);
        q.push_back(e);
    endtask

    // Stream one full line; gap inserts an idle cycle and a blanking pixel after column 2.
    task automatic send_line(input int seq, input int v, input logic primed, input logic gap,
                             input int ev_v);
        for (int h = 0; h < HRES; h++) begin
            drive(1'b1, h, v, pix(seq, h), primed, seq, ev_v);
            if (gap && h == 2) begin
                drive(1'b0, 1, v, 16'hBEEF, 1'b0, seq, 0);
                drive(1'b1, HRES, v, 16'hDEAD, 1'b0, seq, 0);
            end
        end
    endtask

    // Monitor: compare the due record, or require that outputs hold when invalid.
    logic [47:0] last_d = '0;
    logic [10:0] last_h = '0;
    logic [9:0]  last_v = '0;
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            last_d = '0;
            last_h = '0;
            last_v = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("data_valid_out", 48'(data_valid_out), 48'(e.valid));
            if (e.valid) begin
                chk("data_out", data_out, e.data);
                chk("hcount_out", 48'(hcount_out), 48'(e.h));
                chk("vcount_out", 48'(vcount_out), 48'(e.v));
                last_d = e.data;
                last_h = e.h;
                last_v = e.v;
            end else begin
                chk("hold data_out", data_out, last_d);
                chk("hold hcount_out", 48'(hcount_out), 48'(last_h));
                chk("hold vcount_out", 48'(vcount_out), 48'(last_v));
            end
        end else if (data_valid_out) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got 1 expected 0 (t=%0t)", $time);
        end
    end

    // Expected centre line for an input line: 0->6, 1->7, otherwise v-2.
    function automatic int centre(input int v);
        return (v < 2) ? v + VRES - 2 : v - 2;
    endfunction

    initial begin
        // Reset held from time zero.
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset data_out", data_out, 48'd0);
        chk("reset hcount_out", 48'(hcount_out), 48'd0);
        chk("reset vcount_out", 48'(vcount_out), 48'd0);
        chk("reset data_valid_out", 48'(data_valid_out), 48'd0);
        rst_in = 1'b1;

        // Lines 0..7 of frame 0 (priming for the first three), gap/blanking inside line 5.
        for (int s = 0; s < VRES; s++) begin
            send_line(s, s, s >= 3, s == 5, centre(s));
        end
        // Frame wrap: next frame lines 0 and 1 use the previous frame's bottom lines.
        send_line(8, 0, 1'b1, 1'b0, centre(0));
        send_line(9, 1, 1'b1, 1'b0, centre(1));

        // Partial line, then asynchronous reset mid-cycle.
        for (int h = 0; h < 3; h++) begin
            drive(1'b1, h, 2, pix(10, h), 1'b1, 10, centre(2));
        end
        #3;
        rst_in = 1'b0;
        q.delete();
        #1;
        chk("midreset data_out", data_out, 48'd0);
        chk("midreset hcount_out", 48'(hcount_out), 48'd0);
        chk("midreset vcount_out", 48'(vcount_out), 48'd0);
        chk("midreset data_valid_out", 48'(data_valid_out), 48'd0);
        @(posedge clk_in);
        #1;
        chk("inreset data_valid_out", 48'(data_valid_out), 48'd0);
        rst_in = 1'b1;

        // Priming restarts after reset; new tags distinguish from stale bank contents.
        for (int s = 0; s < 4; s++) begin
            send_line(20 + s, 4 + s, s >= 3, 1'b0, centre(4 + s));
        end

        // Flush the pipeline with idle cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 0, 16'h0000, 1'b0, 0, 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk_in);
        end
        @(negedge clk_in);
        chk("scoreboard drained", 48'(q.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Sequences the 3x3 convolution datapath. Accepts the raw 16-bit RGB565 pixel stream with its hcount/vcount.
- Stores the last lines in four rotating line memories and presents three vertically aligned pixels per column on data_out. The convolution block's data_in/hcount_in/vcount_in/data_valid_in connect straight to these outputs.
- Handles write-bank rotation, a 2-cycle BRAM-style read pipeline, vertical coordinate re-centring, and suppresses valid output until enough lines have been captured.

Parameters:
- HRES, 1280, active pixels per line (legal hcount_in range 0..HRES-1)
- VRES, 720, active lines per frame (legal vcount_in range 0..VRES-1)

Ports:
- clk_in  input  1  system clock; all state is rising-edge
- rst_in  input  1  asynchronous, active-low reset
- pixel_in  input  16  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
- hcount_in  input  11  column of pixel_in
- vcount_in  input  10  line of pixel_in
- data_valid_in  input  1  pixel_in/hcount_in/vcount_in are valid this cycle
- data_out  output  3x16 packed ([2:0][15:0])  column pixels; [0]=line v-3 (top), [1]=line v-2 (centre), [2]=line v-1 (bottom)
- hcount_out  output  11  column of data_out
- vcount_out  output  10  centre line of data_out
- data_valid_out  output  1  data_out/hcount_out/vcount_out valid

Behaviour:
- Reset (rst_in low, async): wr_sel=0, fill_cnt=0, all pipeline valid bits=0, data_out=0, hcount_out=0, vcount_out=0, data_valid_out=0. Memory contents are not cleared. Deassertion is sampled synchronously.
- Storage: four banks of HRES x 16 bits, each with 1-cycle registered read.
- Accept condition: acc = data_valid_in && hcount_in < HRES. hcount_in >= HRES is treated as blanking: no write, no rotate, no output valid.
- On acc, cycle T:
  - bank[wr_sel][hcount_in] <= pixel_in.
  - Read address hcount_in is issued to banks wr_sel+1, wr_sel+2, wr_sel+3 (mod 4), mapped to data_out[0], [1], [2] respectively.
  - Read banks are always disjoint from the write bank, so no read-during-write hazard exists.
- Latency: exactly 2 cycles. Inputs accepted at edge T appear on the outputs after edge T+2. The stage-1 register holds valid, hcount, vcount and the bank mapping. Stage 2 registers the memory outputs.
- The bank mapping used for a read is the wr_sel sampled in stage 1. A rotation in the same cycle does not affect reads already in flight.
- Rotation: on acc with hcount_in == HRES-1, wr_sel <= wr_sel+1 mod 4 (wraps 3->0). In the same cycle fill_cnt <= min(fill_cnt+1, 3).
- data_valid_out is set 2 cycles after acc only if fill_cnt == 3 at stage 1. While priming, accepted pixels are written but no output valid is produced.
- fill_cnt is not cleared at frame start. After the first 3 lines following reset, output is continuous across frames, with top lines of a frame using the previous frame's bottom lines.
- vcount_out = vcount_in - 2 mod VRES: 0 -> VRES-2, 1 -> VRES-1. hcount_out = hcount_in, delayed.
- Gaps (data_valid_in low) stall nothing. The pipeline shifts every cycle, and valid bubbles propagate as data_valid_out=0. data_out/hcount_out/vcount_out hold their last values while invalid.
- Mid-line reset: all state is cleared immediately. After reset, writes restart in bank 0 and priming restarts.
- Throughput: one pixel per cycle, no backpressure.

Test Plan:
- Reset: HRES=4, VRES=8. Hold rst_in low mid-stream -> all outputs 0 within the same cycle (async), and fill_cnt=0.
- Priming: stream lines 0,1,2 with values 0x0001*(line+1) -> data_valid_out stays 0 throughout. Bank writes are checked via readback once line 3 streams.
- Alignment: after priming, stream line 3 with pixel 0x0004 at h=0..3 -> 2 cycles later data_out = {0x0003, 0x0002, 0x0001} ([2],[1],[0]), vcount_out=1, hcount_out = 0..3, data_valid_out=1 for 4 cycles.
- Bank wrap: continue lines 4..7 -> at line 4, data_out = {0x0004, 0x0003, 0x0002} with wr_sel having wrapped 3->0. Repeat checks through line 7.
- Gaps/blanking: insert data_valid_in=0 cycles and pixels with hcount_in=4 mid-line -> no write, no rotation; data_valid_out low exactly 2 cycles after each gap; subsequent data is correct.
- Frame wrap: line 0 of the next frame -> vcount_out=6; line 1 -> vcount_out=7. Data rows come from the previous frame's lines 5, 6, 7.
